// File: rtl/data_tape_pkg.sv
// data_tape_pkg: widths, owner/state enums and bus payloads shared by the data
// tape arbiter and its single-port tape memory.
package data_tape_pkg;

  localparam int unsigned TAPE_ADDR_W = 15;
  localparam int unsigned TAPE_WORD_W = 14;
  localparam int unsigned TAPE_BYTE_W = 8;
  localparam int unsigned TAPE_DATA_W = 16;
  localparam int unsigned TAPE_MASK_W = 4;
  localparam int unsigned TAPE_DEPTH  = 16384;
  localparam int unsigned STARVE_W    = 4;

  // Which requester a registered read belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DBG  = 2'd3
  } owner_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } arb_state_t;

  // Byte-wide access as presented by a requester.
  typedef struct packed {
    logic                   we;
    logic [TAPE_ADDR_W-1:0] addr;
    logic [TAPE_BYTE_W-1:0] wdata;
  } port_req_t;

  // Word-wide access as presented to the tape memory.
  typedef struct packed {
    logic                   we;
    logic [TAPE_MASK_W-1:0] mask;
    logic [TAPE_WORD_W-1:0] addr;
    logic [TAPE_DATA_W-1:0] wdata;
  } mem_req_t;

  // Read-return tag: owner of the read in flight plus its byte lane.
  typedef struct packed {
    owner_t owner;
    logic   lane;
  } rd_tag_t;

endpackage

// File: rtl/spram.sv
// spram: 16384 x 16 single-port RAM with nibble write mask and registered
// read data (read-before-write on the same address).
module spram
  import data_tape_pkg::*;
(
  input  logic                   clk,
  input  logic [TAPE_WORD_W-1:0] i_addr,
  input  logic [TAPE_DATA_W-1:0] i_wdata,
  input  logic [TAPE_MASK_W-1:0] i_maskwe,
  input  logic                   i_we,
  output logic [TAPE_DATA_W-1:0] o_rdata
);

  logic [TAPE_DATA_W-1:0] r_mem [TAPE_DEPTH];

  // Masked nibble writes and a registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < int'(TAPE_MASK_W); i++) begin
        if (i_maskwe[i]) begin
          r_mem[i_addr][4*i +: 4] <= i_wdata[4*i +: 4];
        end
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/data_tape_arbiter.sv
// data_tape_arbiter: owns the 32 KiB brainfuck data tape and issues one access
// per cycle to VGA, the clear engine, the CPU or the debug port.
// Optional debug port and starvation counter: define DATA_TAPE_DBG_EN.
module data_tape_arbiter
  import data_tape_pkg::*;
#(
  parameter int unsigned DBG_STARVE = 15
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vga_req,
  input  logic [TAPE_ADDR_W-1:0] vga_addr,
  output logic                   vga_rvalid,
  output logic [TAPE_BYTE_W-1:0] vga_rdata,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [TAPE_ADDR_W-1:0] cpu_addr,
  input  logic [TAPE_BYTE_W-1:0] cpu_wdata,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  output logic [TAPE_BYTE_W-1:0] cpu_rdata,
  input  logic                   dbg_req,
  input  logic                   dbg_we,
  input  logic [TAPE_ADDR_W-1:0] dbg_addr,
  input  logic [TAPE_BYTE_W-1:0] dbg_wdata,
  output logic                   dbg_gnt,
  output logic                   dbg_rvalid,
  output logic [TAPE_BYTE_W-1:0] dbg_rdata,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_done
);

  localparam logic [TAPE_WORD_W-1:0] LAST_WORD = TAPE_WORD_W'(TAPE_DEPTH - 1);
  localparam logic [TAPE_MASK_W-1:0] MASK_HI   = 4'b1100;
  localparam logic [TAPE_MASK_W-1:0] MASK_LO   = 4'b0011;

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [TAPE_WORD_W-1:0] r_clr_word;
  rd_tag_t                r_tag;

  port_req_t              w_cpu;
  port_req_t              w_dbg;
  logic                   w_dbg_req;
  logic                   w_dbg_force;

  owner_t                 w_issue;
  port_req_t              w_sel;
  logic                   w_clear_wr;
  logic                   w_clear_last;
  logic                   w_cpu_gnt;
  logic                   w_dbg_gnt;

  mem_req_t               w_mem;
  logic [TAPE_DATA_W-1:0] w_mem_rdata;
  logic [TAPE_BYTE_W-1:0] w_rd_byte;

  assign w_cpu.we    = cpu_we;
  assign w_cpu.addr  = cpu_addr;
  assign w_cpu.wdata = cpu_wdata;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a clear runs until its last word has been written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear_req)    w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_clear_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: pick this cycle's single access and raise the matching grant.
  always_comb begin
    w_issue    = OWN_NONE;
    w_sel      = '0;
    w_clear_wr = 1'b0;
    w_cpu_gnt  = 1'b0;
    w_dbg_gnt  = 1'b0;
    if (!reset) begin
      if (vga_req) begin
        w_issue    = OWN_VGA;
        w_sel.we   = 1'b0;
        w_sel.addr = vga_addr;
      end else if (r_state == S_CLEAR) begin
        w_clear_wr = 1'b1;
      end else if (w_dbg_force) begin
        w_issue   = OWN_DBG;
        w_sel     = w_dbg;
        w_dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        w_issue   = OWN_CPU;
        w_sel     = w_cpu;
        w_cpu_gnt = 1'b1;
      end else if (w_dbg_req) begin
        w_issue   = OWN_DBG;
        w_sel     = w_dbg;
        w_dbg_gnt = 1'b1;
      end
    end
  end

  assign w_clear_last = w_clear_wr && (r_clr_word == LAST_WORD);

  // Map the chosen byte access onto the 16-bit tape word (or a clear write).
  always_comb begin
    w_mem = '0;
    if (w_clear_wr) begin
      w_mem.we    = 1'b1;
      w_mem.mask  = '1;
      w_mem.addr  = r_clr_word;
      w_mem.wdata = '0;
    end else if (w_issue != OWN_NONE) begin
      w_mem.we    = w_sel.we;
      w_mem.mask  = w_sel.addr[TAPE_ADDR_W-1] ? MASK_HI : MASK_LO;
      w_mem.addr  = w_sel.addr[TAPE_WORD_W-1:0];
      w_mem.wdata = {2{w_sel.wdata}};
    end
  end

  // Clear word counter; wraps to 0 on the last word so the next clear starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_word <= '0;
    end else if (w_clear_wr) begin
      r_clr_word <= r_clr_word + TAPE_WORD_W'(1);
    end
  end

  // Read-return tag: remembers who issued a read this cycle and which lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag.owner <= OWN_NONE;
      r_tag.lane  <= 1'b0;
    end else begin
      r_tag.owner <= (w_issue != OWN_NONE && !w_sel.we) ? w_issue : OWN_NONE;
      r_tag.lane  <= w_sel.addr[TAPE_ADDR_W-1];
    end
  end

  spram data_mem (
    .clk      (clk),
    .i_addr   (w_mem.addr),
    .i_wdata  (w_mem.wdata),
    .i_maskwe (w_mem.mask),
    .i_we     (w_mem.we),
    .o_rdata  (w_mem_rdata)
  );

  assign w_rd_byte = r_tag.lane ? w_mem_rdata[TAPE_DATA_W-1:TAPE_BYTE_W]
                                : w_mem_rdata[TAPE_BYTE_W-1:0];

  assign vga_rvalid = (r_tag.owner == OWN_VGA);
  assign vga_rdata  = vga_rvalid ? w_rd_byte : '0;
  assign cpu_gnt    = w_cpu_gnt;
  assign cpu_rvalid = (r_tag.owner == OWN_CPU);
  assign cpu_rdata  = cpu_rvalid ? w_rd_byte : '0;
  assign dbg_gnt    = w_dbg_gnt;
  assign clear_busy = (r_state == S_CLEAR);
  assign clear_done = w_clear_last;

`ifdef DATA_TAPE_DBG_EN
  logic [STARVE_W-1:0] r_starve;

  assign w_dbg_req   = dbg_req;
  assign w_dbg.we    = dbg_we;
  assign w_dbg.addr  = dbg_addr;
  assign w_dbg.wdata = dbg_wdata;
  assign w_dbg_force = dbg_req && (r_starve == STARVE_W'(DBG_STARVE));

  // Starvation counter: counts consecutive lost debug cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!dbg_req || w_dbg_gnt) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_W'(DBG_STARVE)) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

  assign dbg_rvalid = (r_tag.owner == OWN_DBG);
  assign dbg_rdata  = dbg_rvalid ? w_rd_byte : '0;
`else
  logic w_unused_dbg;

  assign w_dbg_req    = 1'b0;
  assign w_dbg        = '0;
  assign w_dbg_force  = 1'b0;
  assign w_unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata, STARVE_W'(DBG_STARVE)};
  assign dbg_rvalid   = 1'b0;
  assign dbg_rdata    = '0;
`endif

endmodule

// File: tb/tb_data_tape_arbiter.sv
// tb_data_tape_arbiter: randomized and directed stimulus for data_tape_arbiter,
// checked every cycle against a byte-addressed tape model.
module tb_data_tape_arbiter;

  localparam int TB_STARVE = 15;
  localparam int NBYTES    = 32768;
  localparam int NWORDS    = 16384;

  localparam int W_NONE = 0;
  localparam int W_VGA  = 1;
  localparam int W_CLR  = 2;
  localparam int W_CPU  = 3;
  localparam int W_DBG  = 4;

`ifdef DATA_TAPE_DBG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_req;
  logic [14:0] vga_addr;
  logic        vga_rvalid;
  logic [7:0]  vga_rdata;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [14:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [7:0]  dbg_rdata;
  logic        clear_req, clear_busy, clear_done;

  data_tape_arbiter #(.DBG_STARVE(TB_STARVE)) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  // Reference model: the tape as a flat byte array plus clear/starvation bookkeeping.
  logic [7:0] m_tape  [NBYTES];
  bit         m_known [NBYTES];
  bit         m_clearing = 1'b0;
  int         m_word     = 0;
  int         m_starve   = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic       s_cpu_gnt, s_dbg_gnt, s_done, s_busy, s_cpu_rvalid;
  logic [7:0] s_cpu_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: predict, compare grants before the edge, results after it.
  task automatic step();
    int         win;
    int         rd_own;
    int         a;
    logic [7:0] rd_data;
    bit         rd_known;
    bit         exp_done;
    #2;
    win      = W_NONE;
    exp_done = 1'b0;
    if (!reset) begin
      if (vga_req) win = W_VGA;
      else if (m_clearing) begin
        win      = W_CLR;
        exp_done = (m_word == NWORDS - 1);
      end
      else if (DBG_EN && dbg_req && m_starve == TB_STARVE) win = W_DBG;
      else if (cpu_req) win = W_CPU;
      else if (DBG_EN && dbg_req) win = W_DBG;
    end
    s_cpu_gnt = cpu_gnt;
    s_dbg_gnt = dbg_gnt;
    s_done    = clear_done;
    check_eq("cpu_gnt", cpu_gnt, win == W_CPU);
    check_eq("dbg_gnt", dbg_gnt, win == W_DBG);
    check_eq("clear_done", clear_done, exp_done);

    rd_own   = W_NONE;
    rd_data  = 8'h00;
    rd_known = 1'b1;
    case (win)
      W_VGA: begin
        a = int'(vga_addr);
        rd_own = W_VGA; rd_data = m_tape[a]; rd_known = m_known[a];
      end
      W_CPU: begin
        a = int'(cpu_addr);
        if (cpu_we) begin m_tape[a] = cpu_wdata; m_known[a] = 1'b1; end
        else begin rd_own = W_CPU; rd_data = m_tape[a]; rd_known = m_known[a]; end
      end
      W_DBG: begin
        a = int'(dbg_addr);
        if (dbg_we) begin m_tape[a] = dbg_wdata; m_known[a] = 1'b1; end
        else begin rd_own = W_DBG; rd_data = m_tape[a]; rd_known = m_known[a]; end
      end
      W_CLR: begin
        m_tape[m_word] = 8'h00;          m_known[m_word] = 1'b1;
        m_tape[m_word + NWORDS] = 8'h00; m_known[m_word + NWORDS] = 1'b1;
      end
      default: ;
    endcase

    if (reset) begin
      if (m_clearing)
        for (int i = 0; i < NBYTES; i++) m_known[i] = 1'b0;
      m_clearing = 1'b0;
      m_word     = 0;
      m_starve   = 0;
    end else begin
      if (DBG_EN) begin
        if (!dbg_req || win == W_DBG) m_starve = 0;
        else if (m_starve < TB_STARVE) m_starve++;
      end
      if (win == W_CLR) begin
        if (m_word == NWORDS - 1) begin m_clearing = 1'b0; m_word = 0; end
        else m_word++;
      end else if (!m_clearing && clear_req) begin
        m_clearing = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    s_busy       = clear_busy;
    s_cpu_rvalid = cpu_rvalid;
    s_cpu_rdata  = cpu_rdata;
    check_eq("vga_rvalid", vga_rvalid, rd_own == W_VGA);
    check_eq("cpu_rvalid", cpu_rvalid, rd_own == W_CPU);
    check_eq("dbg_rvalid", dbg_rvalid, rd_own == W_DBG);
    if (rd_own != W_VGA || rd_known)
      check_eq("vga_rdata", vga_rdata, (rd_own == W_VGA) ? rd_data : 8'h00);
    if (rd_own != W_CPU || rd_known)
      check_eq("cpu_rdata", cpu_rdata, (rd_own == W_CPU) ? rd_data : 8'h00);
    if (rd_own != W_DBG || rd_known)
      check_eq("dbg_rdata", dbg_rdata, (rd_own == W_DBG) ? rd_data : 8'h00);
    check_eq("clear_busy", clear_busy, m_clearing);
    @(negedge clk);
  endtask

  // CPU access held until granted, with a bounded wait.
  task automatic cpu_access(input bit we, input logic [14:0] a, input logic [7:0] d);
    int guard;
    guard     = 0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    do begin
      step();
      guard++;
    end while (!s_cpu_gnt && guard < 64);
    check_eq("cpu_gnt_wait", s_cpu_gnt, 1'b1);
    cpu_req = 1'b0;
  endtask

  function automatic logic [14:0] rand_addr();
    logic [14:0] a;
    a     = 15'h0010 + 15'($urandom_range(0, 7));
    a[14] = 1'($urandom_range(0, 1));
    return a;
  endfunction

  initial begin
    int first_gnt, losses, busy_n, done_n, n_gnt;
    bit got;
    reset = 1'b1; vga_req = 1'b0; vga_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    clear_req = 1'b0;
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    step();

    // Byte lanes: 0x4005 and 0x0005 share a word but not a byte.
    cpu_access(1'b1, 15'h0005, 8'h5A);
    cpu_access(1'b1, 15'h4005, 8'h41);
    cpu_access(1'b0, 15'h4005, 8'h00);
    check_eq("rd_4005_valid", s_cpu_rvalid, 1'b1);
    check_eq("rd_4005_data", s_cpu_rdata, 8'h41);
    cpu_access(1'b0, 15'h0005, 8'h00);
    check_eq("rd_0005_data", s_cpu_rdata, 8'h5A);

    // VGA holds the memory for 3 cycles; the CPU write waits.
    cpu_access(1'b1, 15'h0010, 8'hC3);
    first_gnt = -1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0011; cpu_wdata = 8'h77;
    for (int c = 0; c < 8; c++) begin
      vga_req  = (c < 3);
      vga_addr = 15'h0010;
      step();
      if (s_cpu_gnt) begin
        if (first_gnt < 0) first_gnt = c;
        cpu_req = 1'b0;
      end
    end
    vga_req = 1'b0;
    check_eq("cpu_first_gnt", first_gnt, 3);

`ifdef DATA_TAPE_DBG_EN
    // Debug contends with a CPU that never lets go.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 15'h4005;
    losses = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (s_dbg_gnt) got = 1'b1;
      else losses++;
    end
    check_eq("dbg_losses", losses, TB_STARVE);
    step();
    check_eq("cpu_after_dbg", s_cpu_gnt, 1'b1);
    dbg_req = 1'b0; cpu_req = 1'b0;
    step();
`else
    // Debug port compiled out: a held debug request must not disturb the CPU.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 15'h0005; dbg_wdata = 8'hEE;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
    n_gnt = 0; got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_cpu_gnt) n_gnt++;
      if (s_dbg_gnt) got = 1'b1;
    end
    check_eq("cpu_gnts_nodbg", n_gnt, 20);
    check_eq("dbg_gnt_nodbg", got, 1'b0);
    check_eq("rd_0005_nodbg", s_cpu_rdata, 8'h5A);
    dbg_req = 1'b0; cpu_req = 1'b0;
    step();
`endif

    // Random mix of VGA, CPU and debug traffic over a small address pool.
    for (int c = 0; c < 3000; c++) begin
      vga_req  = ($urandom_range(0, 99) < 30);
      vga_addr = rand_addr();
      if (!cpu_req && $urandom_range(0, 1) == 1) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
      end
      if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = rand_addr(); dbg_wdata = 8'($urandom);
      end
      step();
      if (s_cpu_gnt) cpu_req = 1'b0;
      if (s_dbg_gnt) dbg_req = 1'b0;
    end
    vga_req = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    step();

    // Fill the whole tape with 0xFF, then zero it with the clear engine.
    for (int a = 0; a < NBYTES; a++) cpu_access(1'b1, 15'(a), 8'hFF);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check_eq("clr_busy_start", s_busy, 1'b1);
    busy_n = 0; done_n = 0;
    while (s_busy && busy_n < 20000) begin
      busy_n++;
      step();
      if (s_done) done_n++;
    end
    check_eq("clr_busy_len", busy_n, NWORDS);
    check_eq("clr_done_cnt", done_n, 1);
    cpu_access(1'b0, 15'h0000, 8'h00); check_eq("clr_rd_0000", s_cpu_rdata, 8'h00);
    cpu_access(1'b0, 15'h3FFF, 8'h00); check_eq("clr_rd_3fff", s_cpu_rdata, 8'h00);
    cpu_access(1'b0, 15'h4000, 8'h00); check_eq("clr_rd_4000", s_cpu_rdata, 8'h00);
    cpu_access(1'b0, 15'h7FFF, 8'h00); check_eq("clr_rd_7fff", s_cpu_rdata, 8'h00);

    // Reset lands on clear word 100.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 100; c++) step();
    reset = 1'b1;
    step();
    check_eq("rst_busy", s_busy, 1'b0);
    check_eq("rst_cpu_rvalid", s_cpu_rvalid, 1'b0);
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0000;
    step();
    check_eq("post_rst_gnt", s_cpu_gnt, 1'b1);
    cpu_req = 1'b0;
    step();
    check_eq("post_rst_busy", s_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
